// File: rtl/shift_out_serializer_pkg.sv
// +--------------------------------------------------------------------+
// | shift_out_serializer_pkg: shared state encodings and word width     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package shift_out_serializer_pkg;

  // Word width shared with the barrel shifter top.
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

endpackage

`default_nettype wire

// File: rtl/ser_hold_reg.sv
// +--------------------------------------------------------------------+
// | ser_hold_reg: one-entry holding register for the next word          |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module ser_hold_reg
  import shift_out_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Load only happens while empty and drain only while full, so they never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_out_serializer.sv
// +--------------------------------------------------------------------+
// | shift_out_serializer: parallel word to framed serial bit stream     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module shift_out_serializer
  import shift_out_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 0,
  parameter int CW        = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic             SER_OUT,
  output logic             SER_VALID,
  input  logic             SER_READY,
  output logic             FRAME_START,
  output logic             FRAME_END,
  output logic             BUSY
);

  ser_state_t       state, state_next;
  logic [WIDTH-1:0] sreg, sreg_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             hold_valid, hold_load, hold_drain;
  logic [WIDTH-1:0] hold_data;
  logic             accept, last;

  assign accept = IN_VALID & ~hold_valid;
  assign last   = (cnt == CW'(WIDTH - 1));

  ser_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (CLK),
    .rst      (RST),
    .load     (hold_load),
    .load_data(IN_DATA),
    .drain    (hold_drain),
    .valid    (hold_valid),
    .data     (hold_data)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      sreg  <= sreg_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    sreg_next  = sreg;
    cnt_next   = cnt;
    hold_load  = 1'b0;
    hold_drain = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          sreg_next  = IN_DATA;
          cnt_next   = '0;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (SER_READY) begin
          if (last) begin
            // Held word first; otherwise a same-cycle accept bypasses the hold register.
            if (hold_valid) begin
              sreg_next  = hold_data;
              cnt_next   = '0;
              hold_drain = 1'b1;
            end else if (accept) begin
              sreg_next = IN_DATA;
              cnt_next  = '0;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            cnt_next  = cnt + CW'(1);
            sreg_next = (MSB_FIRST != 0) ? (sreg << 1) : (sreg >> 1);
          end
        end
        hold_load = accept & ~(SER_READY & last);
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign IN_READY    = ~hold_valid;
  assign SER_VALID   = (state == ST_SHIFT);
  assign SER_OUT     = SER_VALID & ((MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0]);
  assign FRAME_START = SER_VALID & (cnt == '0);
  assign FRAME_END   = SER_VALID & last;
  assign BUSY        = (state == ST_SHIFT) | hold_valid;

endmodule

`default_nettype wire

// File: doc/shift_out_serializer.md
Name: shift_out_serializer

Overview:
- Downstream stage of the 8-bit barrel shifter.
- Takes each parallel OUT word from the shifter over a valid/ready handshake and transmits it serially, one bit per accepted cycle, with frame start/end markers.
- A one-entry holding register lets the shifter hand over the next word while the current word is still shifting, so consecutive words stream without a bubble.

Parameters:
- WIDTH, 8, word width; matches the barrel shifter OUT width.
- MSB_FIRST, 0, 0 = transmit bit 0 first, 1 = transmit bit WIDTH-1 first.
- CW, 3, bit-counter width; must satisfy 2**CW >= WIDTH.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- IN_DATA  in  WIDTH  parallel word from the barrel shifter OUT.
- IN_VALID  in  1  IN_DATA is valid.
- IN_READY  out  1  block can accept a word this cycle.
- SER_OUT  out  1  current serial bit.
- SER_VALID  out  1  SER_OUT holds a valid bit.
- SER_READY  in  1  downstream consumes the bit this cycle.
- FRAME_START  out  1  current bit is the first bit of a word.
- FRAME_END  out  1  current bit is the last bit of a word.
- BUSY  out  1  a word is shifting or a word is held.

Behaviour:
- Handshakes
  - Accept: IN_VALID & IN_READY at a rising edge.
  - Bit transfer: SER_VALID & SER_READY at a rising edge.
  - IN_DATA may change freely when no accept occurs.
- State
  - state: IDLE or SHIFT.
  - sreg: WIDTH-bit shift register.
  - cnt: CW-bit index of the current bit.
  - hold_data / hold_valid: one-entry holding register.
- Reset (RST=1 at an edge): state=IDLE, sreg=0, cnt=0, hold_valid=0, hold_data=0.
  - Resulting outputs: SER_VALID=0, SER_OUT=0, FRAME_START=0, FRAME_END=0, BUSY=0, IN_READY=1.
  - Reset mid-frame discards the partial word and any held word. No further bits of it appear.
- IN_READY = ~hold_valid. Registered-state decode only; no combinational path from SER_READY or IN_VALID.
- IDLE
  - On accept: sreg<=IN_DATA, cnt<=0, state<=SHIFT.
  - Latency: word accepted at edge N, first bit valid in the cycle after edge N.
- SHIFT
  - SER_VALID=1.
  - SER_OUT = sreg[0] if MSB_FIRST=0, else sreg[WIDTH-1].
- Stall: SER_READY=0 holds sreg, cnt and SER_OUT unchanged.
- Bit transfer with cnt<WIDTH-1: cnt<=cnt+1. sreg shifts toward the output end, zero-filled.
- Bit transfer with cnt==WIDTH-1 (last bit), in priority order:
  - hold_valid=1: sreg<=hold_data, cnt<=0, hold_valid<=0, stay SHIFT.
  - else, accept in the same cycle: sreg<=IN_DATA, cnt<=0, stay SHIFT. This path bypasses the hold register.
  - else: state<=IDLE, SER_VALID=0 next cycle.
- Accept while in SHIFT, other than the last-bit bypass case: hold_data<=IN_DATA, hold_valid<=1.
- Back-to-back throughput: one word per WIDTH bit transfers, no idle cycle between frames.
- FRAME_START = SER_VALID & (cnt==0).
- FRAME_END = SER_VALID & (cnt==WIDTH-1).
- For WIDTH=1, FRAME_START and FRAME_END are both high on every bit.
- BUSY = (state==SHIFT) | hold_valid.
- No counter wrap: cnt never exceeds WIDTH-1.

Decomposition:
- Shared package/header:
  - State encodings: ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - Default word width constant: 8, shared with the barrel shifter top.
- Sub-module: ser_hold_reg. Owns the one-entry holding register with its load, drain and valid logic.
- Shift register, counter and FSM stay in the top of the block.

Test Plan:
- Single word: after reset, IN_DATA=8'b00010001, one-cycle IN_VALID, SER_READY=1.
  - SER_OUT LSB-first = 1,0,0,0,1,0,0,0.
  - FRAME_START on bit 0, FRAME_END on bit 7.
  - SER_VALID low and BUSY low the cycle after bit 7.
- MSB_FIRST=1, same word 8'b00010001: SER_OUT = 0,0,0,1,0,0,0,1.
- Back-to-back: offer 8'b00100010, then 8'b01000100 immediately (held), then a third word 8'b10001000.
  - IN_READY drops while the hold register is full.
  - 24 consecutive valid bits with no gap.
  - FRAME_START at bits 0, 8 and 16.
- Stall: SER_READY=0 for 3 cycles at bit 4 of 8'b10101010. SER_OUT stays 0 and cnt stays 4 during the stall; the sequence then resumes intact.
- Last-bit bypass: hold empty, IN_VALID asserted with 8'b11110000 in the same cycle bit 7 of the current word transfers. Next cycle FRAME_START=1 with SER_OUT=0, no idle cycle.
- Reset mid-frame: RST=1 at bit 3 with a word held. Next cycle SER_VALID=0, BUSY=0, IN_READY=1, and neither the partial nor the held word is emitted.
